// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the fetch/data memory arbiter.
package mem_arb_pkg;

   // FSM encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   // Requester identities
   localparam logic OWN_F = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Round-robin pick: on a tie the requester that was not served last wins.
   function automatic logic pick_owner(input logic f_req,
                                       input logic d_req,
                                       input logic last_grant);
      if (f_req && d_req) begin
         return ~last_grant;
      end else if (d_req) begin
         return OWN_D;
      end else begin
         return OWN_F;
      end
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory port.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_ack;
   logic              f_err;
   logic [DATA_W-1:0] f_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic              d_err;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdy;

   modport master (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
      output f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
             mem_re, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
      input  f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
             mem_re, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_watchdog.sv
// Access watchdog: counts ACCESS cycles and flags the last allowed one.
module arb_watchdog #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [7:0] cnt_q, cnt_d;

   // Next count: clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus,
   output logic          busy
);
   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              ok_q, ok_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              wd_clr, wd_en, wd_exp;

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_exp)
   );

   // Next-state: grant in IDLE, wait for ready or timeout in ACCESS, respond in RESP
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      ok_d      = ok_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      wd_clr    = 1'b0;
      wd_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.f_req || bus.d_req) begin
               owner_d = pick_owner(bus.f_req, bus.d_req, last_q);
               if (owner_d == OWN_D) begin
                  addr_d  = bus.d_addr;
                  we_d    = bus.d_we;
                  wdata_d = bus.d_wdata;
               end else begin
                  addr_d  = bus.f_addr;
                  we_d    = 1'b0;
               end
               wd_clr  = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            wd_en = 1'b1;
            if (bus.mem_rdy) begin
               ok_d = 1'b1;
               if (!we_q) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_d = bus.mem_rdata;
                  end else begin
                     f_rdata_d = bus.mem_rdata;
                  end
               end
               state_d = RESP;
            end else if (wd_exp) begin
               ok_d    = 1'b0;
               state_d = RESP;
            end
         end
         RESP: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_F;
         we_q      <= 1'b0;
         ok_q      <= 1'b0;
         last_q    <= OWN_F;
         addr_q    <= '0;
         wdata_q   <= '0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         ok_q      <= ok_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Strobes and response pulses decode straight from registered state
   always_comb begin
      bus.mem_re    = (state_q == ACCESS) && !we_q;
      bus.mem_we    = (state_q == ACCESS) && we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.f_ack     = (state_q == RESP) && ok_q  && (owner_q == OWN_F);
      bus.f_err     = (state_q == RESP) && !ok_q && (owner_q == OWN_F);
      bus.d_ack     = (state_q == RESP) && ok_q  && (owner_q == OWN_D);
      bus.d_err     = (state_q == RESP) && !ok_q && (owner_q == OWN_D);
      bus.f_rdata   = f_rdata_q;
      bus.d_rdata   = d_rdata_q;
      busy          = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, reset-in-flight sequence, random pairs.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   errors = 0;
   int   checks = 0;

   // Reference state derived from the arbitration rules
   logic        last_m;
   logic [31:0] f_rd_m, d_rd_m;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          use_f;
      bit          use_d;
      logic [31:0] fa;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [31:0] frd;
      logic [31:0] drd;
      bit          dwe;
      int          flat;   // ACCESS cycle in which memory is ready; 0 = never
      int          dlat;
      logic        first;  // requester expected to be granted first
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one or two requests, play memory, and check every bus cycle until all complete
   task automatic run_pair(input vec_t v, input logic exp_first);
      logic        order[2];
      int          n, idx, acc, cyc, lat;
      logic        cur;
      bit          exp_ok, wr;
      logic [31:0] rd;
      order[0] = exp_first;
      order[1] = ~exp_first;
      n   = (v.use_f && v.use_d) ? 2 : 1;
      idx = 0; acc = 0; cyc = 0;
      bus.f_req   = v.use_f;
      bus.f_addr  = v.fa;
      bus.d_req   = v.use_d;
      bus.d_we    = v.dwe;
      bus.d_addr  = v.da;
      bus.d_wdata = v.dwd;
      while (idx < n && cyc < 200) begin
         @(negedge clk);
         cur    = order[idx];
         lat    = (cur == OWN_D) ? v.dlat : v.flat;
         rd     = (cur == OWN_D) ? v.drd : v.frd;
         wr     = (cur == OWN_D) && v.dwe;
         exp_ok = (lat >= 1) && (lat <= TO);
         if (bus.f_ack || bus.f_err || bus.d_ack || bus.d_err) begin
            check("one_resp", $countones({bus.f_ack, bus.f_err, bus.d_ack, bus.d_err}), 1);
            check("resp_strobes", {bus.mem_re, bus.mem_we}, 2'b00);
            check("resp_kind", (cur == OWN_D) ? {bus.d_ack, bus.d_err} : {bus.f_ack, bus.f_err},
                  exp_ok ? 2'b10 : 2'b01);
            check("access_cycles", acc, exp_ok ? lat : TO);
            if (exp_ok && !wr) begin
               if (cur == OWN_D) d_rd_m = rd; else f_rd_m = rd;
            end
            check("f_rdata", bus.f_rdata, f_rd_m);
            check("d_rdata", bus.d_rdata, d_rd_m);
            if (cur == OWN_D) bus.d_req = 1'b0; else bus.f_req = 1'b0;
            last_m      = cur;
            bus.mem_rdy = 1'b0;
            idx++;
            acc = 0;
         end else if (bus.mem_re || bus.mem_we) begin
            acc++;
            check("strobe", {bus.mem_re, bus.mem_we}, wr ? 2'b01 : 2'b10);
            check("mem_addr", bus.mem_addr, (cur == OWN_D) ? v.da : v.fa);
            if (wr) check("mem_wdata", bus.mem_wdata, v.dwd);
            check("busy_access", busy, 1'b1);
            bus.mem_rdy   = (acc == lat);
            bus.mem_rdata = (acc == lat) ? rd : $urandom();
         end else begin
            // ready and data are don't-care outside ACCESS
            bus.mem_rdy   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom();
         end
         cyc++;
      end
      if (idx < n) begin
         checks++;
         errors++;
         $display("FAIL txn_done: got %0d of %0d completions within 200 cycles", idx, n);
      end
      bus.f_req   = 1'b0;
      bus.d_req   = 1'b0;
      bus.mem_rdy = 1'b0;
   endtask

   function automatic int rnd_lat();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r == 1) return $urandom_range(TO - 1, TO + 1);
      return $urandom_range(1, 4);
   endfunction

   initial begin
      vec_t rv;
      logic fst;
      rst = 1'b1;
      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
      #1 rst = 1'b0;
      #11;
      check("rst_mem_re", bus.mem_re, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_resp", {bus.f_ack, bus.f_err, bus.d_ack, bus.d_err}, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_f_rdata", bus.f_rdata, 32'h0);
      check("rst_d_rdata", bus.d_rdata, 32'h0);
      @(negedge clk);
      rst    = 1'b1;
      last_m = OWN_F;
      f_rd_m = '0;
      d_rd_m = '0;

      tbl[0] = '{use_f:1, use_d:1, fa:32'h100, da:32'h200, dwd:32'h0, frd:32'hAAAA0001,
                 drd:32'hBBBB0002, dwe:0, flat:2, dlat:2, first:OWN_D};
      tbl[1] = '{use_f:1, use_d:1, fa:32'h104, da:32'h204, dwd:32'h55, frd:32'hAAAA0003,
                 drd:32'h0, dwe:1, flat:2, dlat:2, first:OWN_D};
      tbl[2] = '{use_f:1, use_d:0, fa:32'h10, da:32'h0, dwd:32'h0, frd:32'hDEADBEEF,
                 drd:32'h0, dwe:0, flat:1, dlat:0, first:OWN_F};
      tbl[3] = '{use_f:0, use_d:1, fa:32'h0, da:32'h40, dwd:32'h1234, frd:32'h0,
                 drd:32'h0, dwe:1, flat:0, dlat:1, first:OWN_D};
      tbl[4] = '{use_f:0, use_d:1, fa:32'h0, da:32'h44, dwd:32'h0, frd:32'h0,
                 drd:32'h99999999, dwe:0, flat:0, dlat:0, first:OWN_D};
      tbl[5] = '{use_f:0, use_d:1, fa:32'h0, da:32'h48, dwd:32'h0, frd:32'h0,
                 drd:32'hCAFEF00D, dwe:0, flat:0, dlat:TO, first:OWN_D};
      tbl[6] = '{use_f:1, use_d:1, fa:32'h20, da:32'h60, dwd:32'h0, frd:32'h11112222,
                 drd:32'h33334444, dwe:0, flat:3, dlat:1, first:OWN_F};
      for (int i = 0; i < 7; i++) begin
         run_pair(tbl[i], tbl[i].first);
      end

      // Reset asserted while a fetch is in ACCESS
      @(negedge clk);
      bus.f_req  = 1'b1;
      bus.f_addr = 32'h80;
      for (int k = 0; k < 10 && !bus.mem_re; k++) @(negedge clk);
      check("rsq_re_seen", bus.mem_re, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rsq_re_drop", bus.mem_re, 1'b0);
      check("rsq_busy", busy, 1'b0);
      check("rsq_f_rdata", bus.f_rdata, 32'h0);
      bus.f_req = 1'b0;
      @(negedge clk);
      rst    = 1'b1;
      last_m = OWN_F;
      f_rd_m = '0;
      d_rd_m = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rsq_no_resp", {bus.f_ack, bus.f_err, bus.d_ack, bus.d_err}, 4'b0000);
      end
      rv = '{use_f:1, use_d:0, fa:32'h84, da:32'h0, dwd:32'h0, frd:32'h0BADF00D,
             drd:32'h0, dwe:0, flat:2, dlat:0, first:OWN_F};
      run_pair(rv, OWN_F);

      // Random pairs against the round-robin rule
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(1, 3))
            1:       begin rv.use_f = 1; rv.use_d = 0; end
            2:       begin rv.use_f = 0; rv.use_d = 1; end
            default: begin rv.use_f = 1; rv.use_d = 1; end
         endcase
         rv.fa   = $urandom();
         rv.da   = $urandom();
         rv.dwd  = $urandom();
         rv.frd  = $urandom();
         rv.drd  = $urandom();
         rv.dwe  = 1'($urandom_range(0, 1));
         rv.flat = rnd_lat();
         rv.dlat = rnd_lat();
         if (rv.use_f && rv.use_d) fst = (last_m == OWN_F) ? OWN_D : OWN_F;
         else                      fst = rv.use_d ? OWN_D : OWN_F;
         rv.first = fst;
         run_pair(rv, fst);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
